// File: rtl/tour_cmd_seq_if.sv
// Command-path bundle between the UART wrapper, the tour sequencer and the
// command processor. The sequencer itself connects through the slave modport.
// The master modport is the environment side: the UART wrapper plus the command processor.
interface tour_cmd_seq_if;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        resp_UART;

    modport master (
        output cmd_UART,
        output cmd_rdy_UART,
        input  clr_cmd_rdy_UART,
        input  cmd,
        input  cmd_rdy,
        output clr_cmd_rdy,
        output send_resp,
        input  resp_UART
    );

    modport slave (
        input  cmd_UART,
        input  cmd_rdy_UART,
        output clr_cmd_rdy_UART,
        output cmd,
        output cmd_rdy,
        input  clr_cmd_rdy,
        input  send_resp,
        output resp_UART
    );
endinterface

// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer. In IDLE, UART commands pass straight through
// to the command processor. After start_tour, the block replays 24 solver moves.
// Each move is issued as two commands: a vertical leg, then a horizontal leg.
// Optional feature: define TOUR_FANFARE_EN to issue horizontal legs with
// opcode 4'h3 (move with fanfare) instead of 4'h2.
module tour_cmd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    output logic        tour_done,
    output logic        tour_err,
    tour_cmd_seq_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] VERT   = 3'd1;
    localparam logic [2:0] HOLD_V = 3'd2;
    localparam logic [2:0] HORZ   = 3'd3;
    localparam logic [2:0] HOLD_H = 3'd4;

    localparam logic [4:0] LAST_INDX = 5'd23;
    localparam logic [3:0] VERT_OP   = 4'h2;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] HORZ_OP   = 4'h3;
`else
    localparam logic [3:0] HORZ_OP   = 4'h2;
`endif

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       move_ok;
    logic [7:0] vert_head;
    logic [3:0] vert_sq;
    logic [7:0] horz_head;
    logic [3:0] horz_sq;

    assign move_ok = $onehot(move);

    // Split the one-hot move into its vertical and horizontal legs.
    always_comb begin
        vert_head = NORTH;
        vert_sq   = 4'd0;
        horz_head = EAST;
        horz_sq   = 4'd0;
        case (move)
            8'h01: begin vert_head = NORTH; vert_sq = 4'd2; horz_head = WEST; horz_sq = 4'd1; end
            8'h02: begin vert_head = NORTH; vert_sq = 4'd2; horz_head = EAST; horz_sq = 4'd1; end
            8'h04: begin vert_head = NORTH; vert_sq = 4'd1; horz_head = WEST; horz_sq = 4'd2; end
            8'h08: begin vert_head = SOUTH; vert_sq = 4'd1; horz_head = WEST; horz_sq = 4'd2; end
            8'h10: begin vert_head = SOUTH; vert_sq = 4'd2; horz_head = WEST; horz_sq = 4'd1; end
            8'h20: begin vert_head = SOUTH; vert_sq = 4'd2; horz_head = EAST; horz_sq = 4'd1; end
            8'h40: begin vert_head = SOUTH; vert_sq = 4'd1; horz_head = EAST; horz_sq = 4'd2; end
            8'h80: begin vert_head = NORTH; vert_sq = 4'd1; horz_head = EAST; horz_sq = 4'd2; end
            default: begin
                vert_head = NORTH;
                vert_sq   = 4'd0;
                horz_head = EAST;
                horz_sq   = 4'd0;
            end
        endcase
    end

    // Per-state output muxing: pass-through in IDLE, otherwise the leg being replayed.
    always_comb begin
        bus.cmd              = 16'h0000;
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp_UART        = 1'b0;
        tour_done            = 1'b0;
        tour_err             = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd              = bus.cmd_UART;
                bus.cmd_rdy          = bus.cmd_rdy_UART;
                bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
                bus.resp_UART        = bus.send_resp;
            end
            VERT: begin
                bus.cmd     = {VERT_OP, vert_head, vert_sq};
                bus.cmd_rdy = move_ok;
                tour_err    = ~move_ok;
            end
            HOLD_V: begin
                bus.cmd = {VERT_OP, vert_head, vert_sq};
            end
            HORZ: begin
                bus.cmd     = {HORZ_OP, horz_head, horz_sq};
                bus.cmd_rdy = 1'b1;
            end
            HOLD_H: begin
                bus.cmd   = {HORZ_OP, horz_head, horz_sq};
                tour_done = bus.send_resp && (mv_indx == LAST_INDX);
            end
            default: begin
                bus.cmd = 16'h0000;
            end
        endcase
    end

    // Next-state logic; an illegal move word in VERT aborts back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start_tour) next_state = VERT;
            VERT: begin
                if (!move_ok)              next_state = IDLE;
                else if (bus.clr_cmd_rdy)  next_state = HOLD_V;
            end
            HOLD_V: if (bus.send_resp)     next_state = HORZ;
            HORZ:   if (bus.clr_cmd_rdy)   next_state = HOLD_H;
            HOLD_H: begin
                if (bus.send_resp)
                    next_state = (mv_indx == LAST_INDX) ? IDLE : VERT;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register with asynchronous abort to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Move index: cleared at tour start, advanced when a non-final move completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mv_indx <= 5'd0;
        else if (state == IDLE && start_tour)
            mv_indx <= 5'd0;
        else if (state == HOLD_H && bus.send_resp && mv_indx != LAST_INDX)
            mv_indx <= mv_indx + 5'd1;
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Self-checking bench for tour_cmd_seq. Expected leg commands are queued when a
// move is presented and compared as the sequencer raises cmd_rdy.
module tb_tour_cmd_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_tour;
    logic [7:0] move;
    logic [4:0] mv_indx;
    logic       tour_done;
    logic       tour_err;

    tour_cmd_seq_if bus();

    tour_cmd_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .tour_done  (tour_done),
        .tour_err   (tour_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] EXP_HORZ_OP = 4'h3;
`else
    localparam logic [3:0] EXP_HORZ_OP = 4'h2;
`endif

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          cmd_count;
    logic [15:0] exp_q[$];
    logic [7:0]  tour_moves[24];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [15:0] cu, input logic cru,
                                 input logic clr, input logic resp);
        start_tour       = start;
        bus.cmd_UART     = cu;
        bus.cmd_rdy_UART = cru;
        bus.clr_cmd_rdy  = clr;
        bus.send_resp    = resp;
    endtask

    // Reference model: build a leg command from knight displacement arithmetic.
    function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horiz);
        int dx_tab[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
        int dy_tab[8] = '{2, 2, 1, -1, -2, -2, -1, 1};
        int k = 0;
        int d;
        logic [7:0] head;
        logic [3:0] op;
        for (int b = 0; b < 8; b++)
            if (mv[b]) k = b;
        if (horiz) begin
            d    = dx_tab[k];
            head = (d > 0) ? 8'hBF : 8'h3F;
            op   = EXP_HORZ_OP;
        end else begin
            d    = dy_tab[k];
            head = (d > 0) ? 8'h00 : 8'h7F;
            op   = 4'h2;
        end
        if (d < 0) d = -d;
        return {op, head, d[3:0]};
    endfunction

    // Compare the presented leg against the scoreboard head, optionally consuming it.
    task automatic expect_leg(input string tag, input bit pop);
        checkOutput({tag, "_rdy"}, 32'(bus.cmd_rdy), 32'd1);
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        end else begin
            checkOutput(tag, 32'(bus.cmd), 32'(exp_q[0]));
            if (pop) begin
                void'(exp_q.pop_front());
                if (bus.cmd_rdy) cmd_count++;
            end
        end
    endtask

    // Replay the tour in tour_moves; stop in HOLD_H of stop_idx (24 = complete tour).
    task automatic run_tour(input int stop_idx);
        cmd_count = 0;
        @(negedge clk);
        applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
        move = tour_moves[0];
        #1 checkOutput("idle_before_start", 32'(bus.cmd), 32'h1111);
        for (int idx = 0; idx < 24; idx++) begin
            exp_q.push_back(leg_cmd(tour_moves[idx], 1'b0));
            exp_q.push_back(leg_cmd(tour_moves[idx], 1'b1));
            move = tour_moves[idx];
            @(negedge clk);
            applyStimulus(1'b0, 16'h1111, 1'b1, 1'b0, 1'b0);
            #1 checkOutput("mv_indx", 32'(mv_indx), 32'(idx));
            if (idx == 2) begin
                bus.send_resp = 1'b1;
                #1 expect_leg("vert_stall", 1'b0);
                @(negedge clk);
            end
            applyStimulus(1'b0, 16'h1111, 1'b1, 1'b1, 1'(idx % 2));
            #1 expect_leg("vert", 1'b1);
            checkOutput("vert_uart_clr", 32'(bus.clr_cmd_rdy_UART), 32'd0);
            checkOutput("vert_err", 32'(tour_err), 32'd0);
            @(negedge clk);
            if (idx == 4) begin
                applyStimulus(1'b1, 16'h1111, 1'b1, 1'b1, 1'b0);
                #1 checkOutput("hold_v_stall_rdy", 32'(bus.cmd_rdy), 32'd0);
                @(negedge clk);
            end
            applyStimulus(1'b0, 16'h1111, 1'b1, 1'b0, 1'b1);
            #1 checkOutput("hold_v_rdy", 32'(bus.cmd_rdy), 32'd0);
            checkOutput("hold_v_resp_uart", 32'(bus.resp_UART), 32'd0);
            @(negedge clk);
            applyStimulus(1'b0, 16'h1111, 1'b1, 1'b1, 1'(idx % 2));
            #1 expect_leg("horz", 1'b1);
            @(negedge clk);
            applyStimulus(1'b0, 16'h1111, 1'b1, 1'b0, 1'(idx != stop_idx));
            #1 checkOutput("hold_h_rdy", 32'(bus.cmd_rdy), 32'd0);
            checkOutput("tour_done", 32'(tour_done), 32'(idx == 23 && idx != stop_idx));
            if (idx == stop_idx) return;
        end
        @(negedge clk);
        applyStimulus(1'b0, 16'h4242, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("done_pulse_end", 32'(tour_done), 32'd0);
        checkOutput("post_tour_cmd", 32'(bus.cmd), 32'h4242);
        checkOutput("post_tour_rdy", 32'(bus.cmd_rdy), 32'd1);
        checkOutput("post_tour_resp", 32'(bus.resp_UART), 32'd1);
        checkOutput("post_tour_indx", 32'(mv_indx), 32'd23);
        checkOutput("cmd_count", 32'(cmd_count), 32'd48);
        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] bad_moves[3];
        bad_moves = '{8'h03, 8'h00, 8'hFF};
        rst_n = 1'b0;
        move  = 8'h00;
        applyStimulus(1'b0, 16'hABCD, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("reset_indx", 32'(mv_indx), 32'd0);
        checkOutput("reset_done", 32'(tour_done), 32'd0);
        checkOutput("reset_err", 32'(tour_err), 32'd0);
        checkOutput("reset_cmd", 32'(bus.cmd), 32'hABCD);
        checkOutput("reset_rdy", 32'(bus.cmd_rdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        applyStimulus(1'b0, 16'h2005, 1'b1, 1'b1, 1'b1);
        #1 checkOutput("pass_cmd", 32'(bus.cmd), 32'h2005);
        checkOutput("pass_rdy", 32'(bus.cmd_rdy), 32'd1);
        checkOutput("pass_clr", 32'(bus.clr_cmd_rdy_UART), 32'd1);
        checkOutput("pass_resp", 32'(bus.resp_UART), 32'd1);

        tour_moves[0] = 8'h01;
        for (int i = 1; i < 24; i++) tour_moves[i] = 8'(1 << $urandom_range(0, 7));
        run_tour(24);

        foreach (bad_moves[b]) begin
            @(negedge clk);
            applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
            move = bad_moves[b];
            @(negedge clk);
            applyStimulus(1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
            #1 checkOutput("err_pulse", 32'(tour_err), 32'd1);
            checkOutput("err_rdy", 32'(bus.cmd_rdy), 32'd0);
            checkOutput("err_done", 32'(tour_done), 32'd0);
            @(negedge clk);
            #1 checkOutput("err_clears", 32'(tour_err), 32'd0);
            bus.cmd_rdy_UART = 1'b1;
            #1 checkOutput("err_back_idle", 32'(bus.cmd_rdy), 32'd1);
            checkOutput("err_back_cmd", 32'(bus.cmd), 32'h5555);
        end

        tour_moves[0] = 8'h08;
        for (int i = 1; i < 24; i++) tour_moves[i] = 8'(1 << $urandom_range(0, 7));
        run_tour(7);
        @(negedge clk);
        applyStimulus(1'b0, 16'h7777, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1 checkOutput("abort_indx", 32'(mv_indx), 32'd0);
        checkOutput("abort_cmd", 32'(bus.cmd), 32'h7777);
        checkOutput("abort_rdy", 32'(bus.cmd_rdy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 16'h7778, 1'b0, 1'b1, 1'b0);
        #1 checkOutput("abort_pass_rdy", 32'(bus.cmd_rdy), 32'd0);
        checkOutput("abort_pass_cmd", 32'(bus.cmd), 32'h7778);
        checkOutput("abort_pass_clr", 32'(bus.clr_cmd_rdy_UART), 32'd1);
        checkOutput("abort_no_err", 32'(tour_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
